// File: rtl/sc_udp_pkg.sv
// Shared definitions for the slow-control UDP transmit initiator:
// FSM encoding, responder timing defaults and the UDP length helper.
package sc_udp_pkg;

   localparam int DEF_HDR_LEAD  = 11;   // responder header latency, start pulse to byte 0
   localparam int UDP_HDR_BYTES = 8;
   localparam int DEF_TAIL_GAP  = 4;    // idle cycles between done and the next request

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_REQ,
      ST_ACK_LO,
      ST_ACK_HI,
      ST_RDY,
      ST_LEAD,
      ST_STREAM,
      ST_DONE,
      ST_TAIL
   } sc_state_e;

   // UDP length field: 8-byte header plus 4 bytes per payload word, 16-bit wrap
   function automatic logic [15:0] udp_length(input logic [15:0] n_words);
      return 16'(UDP_HDR_BYTES) + {n_words[13:0], 2'b00};
   endfunction

endpackage

// File: rtl/sc_payload_buf.sv
// Payload buffer: simple dual-port MAX_WORDS x 32 RAM with self-incrementing
// write and read pointers and a one-cycle registered read port.
module sc_payload_buf #(
   parameter int MAX_WORDS = 64
) (
   input  logic        clk125m,
   input  logic        reset,
   input  logic        wr_clr,
   input  logic        wr_en,
   input  logic [31:0] wr_data,
   input  logic        rd_clr,
   input  logic        rd_en,
   output logic [31:0] rd_data
);

   localparam int AW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

   logic [31:0]   mem [MAX_WORDS];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW-1:0] wr_addr;

   // wr_clr forces the current write to address 0 so word 0 needs no setup cycle
   assign wr_addr = wr_clr ? '0 : wr_ptr_q;

   // Address counters for both ports
   always_ff @(posedge clk125m) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr_q <= wr_addr + AW'(1);
         end else if (wr_clr) begin
            wr_ptr_q <= '0;
         end
         if (rd_clr) begin
            rd_ptr_q <= '0;
         end else if (rd_en) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
      end
   end

   // Storage write and registered read; rd_data holds until the next rd_en
   always_ff @(posedge clk125m) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_ptr_q];
      end
   end

endmodule

// File: rtl/sc_udp_tx_initiator.sv
// Slow-control UDP transmit initiator: buffers one reply packet, runs the
// req/ack handshake with the sctx responder and streams the payload bytewise.
module sc_udp_tx_initiator #(
   parameter int          MAX_WORDS   = 64,
   parameter logic [15:0] ACK_TIMEOUT = 16'd1024,
   parameter int          HDR_LEAD    = sc_udp_pkg::DEF_HDR_LEAD,
   parameter int          TAIL_GAP    = sc_udp_pkg::DEF_TAIL_GAP
) (
   input  logic        clk125m,
   input  logic        reset,
   input  logic        rp_valid,
   output logic        rp_ready,
   input  logic [31:0] rp_word,
   input  logic        rp_last,
   input  logic [31:0] rp_dst_ip,
   input  logic [15:0] rp_dst_port,
   input  logic [15:0] rp_src_port,
   output logic [15:0] sctx_udptxSrcPort,
   output logic [15:0] sctx_udptxDstPort,
   output logic [31:0] sctx_udptxDstIP,
   output logic [15:0] sctx_length,
   output logic [7:0]  sctx_data,
   output logic        sctx_start,
   output logic        sctx_stop,
   output logic        sctx_req,
   output logic        sctx_done,
   input  logic        sctx_ack,
   input  logic        sctx_txdatardy,
   output logic        busy,
   output logic        trunc,
   output logic        timeout_err
);

   import sc_udp_pkg::*;

   localparam int CW = $clog2(MAX_WORDS + 1);

   sc_state_e   state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic        trunc_seen_q, trunc_seen_d;
   logic [15:0] tmo_q, tmo_d;
   logic [7:0]  lead_q, lead_d;
   logic [15:0] bidx_q, bidx_d;
   logic [31:0] word_q, word_d;
   logic        trunc_q, trunc_d;
   logic        tmo_err_q, tmo_err_d;
   logic        rdy_q;
   logic [15:0] src_port_q, dst_port_q, len_q;
   logic [31:0] dst_ip_q;

   logic        wr_clr, wr_en, rd_clr, rd_en;
   logic [31:0] rd_data;
   logic        accept;
   logic        tmo_hit;
   logic [15:0] last_idx;
   logic [7:0]  data_byte;

   assign accept   = rp_valid & rdy_q;
   assign tmo_hit  = (tmo_q == ACK_TIMEOUT - 16'd1);
   assign last_idx = 16'({count_q, 2'b00}) - 16'd1;

   sc_payload_buf #(
      .MAX_WORDS (MAX_WORDS)
   ) u_buf (
      .clk125m (clk125m),
      .reset   (reset),
      .wr_clr  (wr_clr),
      .wr_en   (wr_en),
      .wr_data (rp_word),
      .rd_clr  (rd_clr),
      .rd_en   (rd_en),
      .rd_data (rd_data)
   );

   // Next-state, buffer control and serializer sequencing
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      trunc_seen_d = trunc_seen_q;
      lead_d       = lead_q;
      bidx_d       = bidx_q;
      word_d       = word_q;
      trunc_d      = 1'b0;
      tmo_err_d    = 1'b0;
      wr_clr       = 1'b0;
      wr_en        = 1'b0;
      rd_clr       = 1'b0;
      rd_en        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            wr_clr = 1'b1;
            if (accept) begin
               wr_en        = 1'b1;
               count_d      = CW'(1);
               trunc_seen_d = 1'b0;
               state_d      = rp_last ? ST_REQ : ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            if (accept) begin
               if (count_q < CW'(MAX_WORDS)) begin
                  wr_en   = 1'b1;
                  count_d = count_q + CW'(1);
               end else if (!trunc_seen_q) begin
                  trunc_d      = 1'b1;
                  trunc_seen_d = 1'b1;
               end
               if (rp_last) begin
                  state_d = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (sctx_ack) begin
               state_d = ST_ACK_LO;
            end else if (tmo_hit) begin
               state_d   = ST_IDLE;
               tmo_err_d = 1'b1;
            end
         end
         ST_ACK_LO: begin
            if (!sctx_ack) begin
               state_d = ST_ACK_HI;
            end else if (tmo_hit) begin
               state_d   = ST_IDLE;
               tmo_err_d = 1'b1;
            end
         end
         ST_ACK_HI: begin
            if (sctx_ack) begin
               state_d = ST_RDY;
            end else if (tmo_hit) begin
               state_d   = ST_IDLE;
               tmo_err_d = 1'b1;
            end
         end
         ST_RDY: begin
            rd_clr = 1'b1;
            if (sctx_txdatardy) begin
               state_d = ST_LEAD;
               lead_d  = 8'd0;
            end else if (tmo_hit) begin
               state_d   = ST_IDLE;
               tmo_err_d = 1'b1;
            end
         end
         ST_LEAD: begin
            // word 0 is fetched on the start cycle; word 1 is fetched as word 0 is loaded
            if (lead_q == 8'd0) begin
               rd_en = 1'b1;
            end
            lead_d = lead_q + 8'd1;
            if (lead_q == 8'(HDR_LEAD - 1)) begin
               state_d = ST_STREAM;
               word_d  = rd_data;
               bidx_d  = 16'd0;
               rd_en   = 1'b1;
            end
         end
         ST_STREAM: begin
            if (bidx_q == last_idx) begin
               state_d = ST_DONE;
            end else begin
               bidx_d = bidx_q + 16'd1;
               if (bidx_q[1:0] == 2'd3) begin
                  word_d = rd_data;
                  rd_en  = 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_TAIL;
            lead_d  = 8'd0;
         end
         ST_TAIL: begin
            lead_d = lead_q + 8'd1;
            if (lead_q == 8'(TAIL_GAP - 1)) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      tmo_d = (state_d != state_q) ? 16'd0 : tmo_q + 16'd1;
   end

   // Control state, header capture and status pulses
   always_ff @(posedge clk125m) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         count_q      <= '0;
         trunc_seen_q <= 1'b0;
         tmo_q        <= 16'd0;
         lead_q       <= 8'd0;
         bidx_q       <= 16'd0;
         trunc_q      <= 1'b0;
         tmo_err_q    <= 1'b0;
         rdy_q        <= 1'b0;
         src_port_q   <= 16'd0;
         dst_port_q   <= 16'd0;
         dst_ip_q     <= 32'd0;
         len_q        <= 16'd0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         trunc_seen_q <= trunc_seen_d;
         tmo_q        <= tmo_d;
         lead_q       <= lead_d;
         bidx_q       <= bidx_d;
         trunc_q      <= trunc_d;
         tmo_err_q    <= tmo_err_d;
         rdy_q        <= (state_d == ST_IDLE) || (state_d == ST_COLLECT);
         if ((state_q == ST_IDLE) && accept) begin
            src_port_q <= rp_src_port;
            dst_port_q <= rp_dst_port;
            dst_ip_q   <= rp_dst_ip;
         end
         if ((state_d == ST_REQ) && (state_q != ST_REQ)) begin
            len_q <= udp_length(16'(count_d));
         end
      end
   end

   // Word being serialized; gated on the output side so it needs no reset
   always_ff @(posedge clk125m) begin
      word_q <= word_d;
   end

   // Byte select: big-endian within the held word, zero outside the stream
   always_comb begin
      data_byte = 8'h00;
      if (state_q == ST_STREAM) begin
         case (bidx_q[1:0])
            2'd0: data_byte = word_q[31:24];
            2'd1: data_byte = word_q[23:16];
            2'd2: data_byte = word_q[15:8];
            2'd3: data_byte = word_q[7:0];
         endcase
      end
   end

   assign rp_ready          = rdy_q;
   assign sctx_udptxSrcPort = src_port_q;
   assign sctx_udptxDstPort = dst_port_q;
   assign sctx_udptxDstIP   = dst_ip_q;
   assign sctx_length       = len_q;
   assign sctx_data         = data_byte;
   assign sctx_start        = (state_q == ST_LEAD) && (lead_q == 8'd0);
   assign sctx_stop         = (state_q == ST_STREAM) && (bidx_q == last_idx);
   assign sctx_req          = (state_q == ST_REQ) || (state_q == ST_ACK_LO) || (state_q == ST_ACK_HI);
   assign sctx_done         = (state_q == ST_DONE);
   assign busy              = (state_q != ST_IDLE);
   assign trunc             = trunc_q;
   assign timeout_err       = tmo_err_q;

endmodule
